// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin merge of S_COUNT AXI-Stream inputs
// Optional mid-frame stall timeout with DRAIN state: define AXIS_FRAME_ARBITER_TIMEOUT_EN.

module axis_frame_arbiter #(
    parameter int                    S_COUNT              = 2,
    parameter int                    DATA_WIDTH           = 8,
    parameter int                    KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
    parameter int                    TIMEOUT              = 256,
    localparam int                   IDX_W                = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_index,
    output logic                          status_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
        ,DRAIN = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] ptr_next;
    logic             req_any;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_WIDTH-1:0] sel_tkeep;
    logic [USER_WIDTH-1:0] sel_tuser;
    logic                  sel_tvalid;
    logic                  sel_tlast;

    assign sel_tdata  = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tkeep  = s_axis_tkeep[gidx_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_tuser  = s_axis_tuser[gidx_q*USER_WIDTH +: USER_WIDTH];
    assign sel_tvalid = s_axis_tvalid[gidx_q];
    assign sel_tlast  = s_axis_tlast[gidx_q];
    assign ptr_next   = (gidx_q == IDX_W'(S_COUNT - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Walk offsets downward so the request closest above the pointer is the last one kept.
    always_comb begin
        int j;
        logic [IDX_W-1:0] idx;
        req_any = |s_axis_tvalid;
        pick    = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= S_COUNT) j = j - S_COUNT;
            idx = IDX_W'(j);
            if (s_axis_tvalid[idx]) pick = idx;
        end
    end

`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             status_q, status_d;
    logic             timeout_hit;

    assign timeout_hit    = (state_q == PASS) && (stall_q == CNT_W'(TIMEOUT));
    assign status_timeout = status_q;
`else
    assign status_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
            stall_q  <= '0;
            status_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
            stall_q  <= stall_d;
            status_q <= status_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
        stall_d  = stall_q;
        status_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gidx_d  = pick;
                    state_d = PASS;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            PASS: begin
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
                // Once the synthetic beat is offered it stays until taken, even if the source returns.
                if (timeout_hit) begin
                    if (m_axis_tready) begin
                        state_d  = DRAIN;
                        status_d = 1'b1;
                    end
                end else if (sel_tvalid) begin
                    stall_d = '0;
                    if (m_axis_tready && sel_tlast) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
`else
                if (sel_tvalid && m_axis_tready && sel_tlast) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                end
`endif
            end
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
            DRAIN: begin
                if (sel_tvalid && sel_tlast) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = sel_tdata;
        m_axis_tkeep  = sel_tkeep;
        m_axis_tuser  = sel_tuser;
        m_axis_tlast  = sel_tlast;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        grant_valid   = (state_q != IDLE);
        grant_index   = gidx_q;
        case (state_q)
            PASS: begin
                m_axis_tvalid         = sel_tvalid;
                s_axis_tready[gidx_q] = m_axis_tready;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
                if (timeout_hit) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = 1'b1;
                    m_axis_tuser  = USER_BAD_FRAME_VALUE;
                    m_axis_tkeep  = '0;
                    m_axis_tdata  = '0;
                    s_axis_tready = '0;
                end
`endif
            end
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
            DRAIN: s_axis_tready[gidx_q] = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - scoreboard bench for axis_frame_arbiter with a frame-level reference model

module tb_axis_frame_arbiter;

    localparam int S  = 3;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [S*DW-1:0] s_tdata = '0;
    logic [S-1:0]  s_tkeep = '0;
    logic [S-1:0]  s_tvalid = '0;
    logic [S-1:0]  s_tready;
    logic [S-1:0]  s_tlast = '0;
    logic [S-1:0]  s_tuser = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          m_tuser;
    logic          gv;
    logic [1:0]    gi;
    logic          stat;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .USER_WIDTH(1),
        .USER_BAD_FRAME_VALUE(1'b1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .grant_valid(gv), .grant_index(gi), .status_timeout(stat)
    );

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic       user;
        logic       last;
        int         gap;
    } beat_t;

    beat_t        src_q [S][$];
    beat_t        exp_q [S][$];
    int           order_q[$];
    int           gapc [S];
    logic [S-1:0] acc = '0;
    int           checks = 0;
    int           errors = 0;
    int           tout_seen = 0;

    // Reference model: 0 = no frame owned, 1 = forwarding, 2 = discarding after a timeout.
    int mst = 0, mown = 0, mptr = 0, mstall = 0;
    bit mstat = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [S-1:0] erdy;
        logic         emv;
        bit           hit;
        bit           found;
        beat_t        b;
        hit = 1'b0;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
        hit = (mst == 1) && (mstall == TO);
`endif
        erdy = '0;
        emv  = 1'b0;
        if (mst == 1 && !hit) begin
            erdy[mown] = m_tready;
            emv        = s_tvalid[mown];
        end
        if (mst == 1 && hit) emv = 1'b1;
        if (mst == 2) erdy[mown] = 1'b1;
        chk("ctl", {56'd0, gv, gi, m_tvalid, s_tready, stat},
            {56'd0, mst != 0, 2'(mown), emv, erdy, mstat});

        acc = s_tvalid & s_tready;
        if (stat) tout_seen++;
        mstat = 1'b0;

        if (mst == 1) begin
            if (hit) begin
                if (m_tready) begin
                    chk("synthetic_beat", {52'd0, m_tdata, m_tkeep, m_tuser, m_tlast}, 64'h3);
                    mst   = 2;
                    mstat = 1'b1;
                end
            end else if (s_tvalid[mown]) begin
                mstall = 0;
                if (m_tready) begin
                    if (exp_q[mown].size() == 0) begin
                        chk("beat_unexpected", 64'd1, 64'd0);
                    end else begin
                        b = exp_q[mown].pop_front();
                        chk("beat", {53'd0, m_tdata, m_tkeep, m_tuser, m_tlast},
                            {53'd0, b.data, b.keep, b.user, b.last});
                        if (b.last) begin
                            order_q.push_back(mown);
                            mptr = (mown + 1) % S;
                            mst  = 0;
                        end
                    end
                end
            end else begin
                mstall++;
            end
        end else if (mst == 2) begin
            if (s_tvalid[mown]) begin
                if (exp_q[mown].size() > 0) b = exp_q[mown].pop_front();
                if (s_tlast[mown]) begin
                    order_q.push_back(mown);
                    mptr = (mown + 1) % S;
                    mst  = 0;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < S; k++) begin
                if (!found && s_tvalid[(mptr + k) % S]) begin
                    found = 1'b1;
                    mown  = (mptr + k) % S;
                end
            end
            if (found) begin
                mst    = 1;
                mstall = 0;
            end
        end

        if (rst) begin
            mst    = 0;
            mown   = 0;
            mptr   = 0;
            mstall = 0;
            mstat  = 1'b0;
        end
    end

    task automatic push_beat(int s, bit last, int gap);
        beat_t b;
        b.data = 8'($urandom);
        b.keep = 1'($urandom);
        b.user = 1'($urandom);
        b.last = last;
        b.gap  = gap;
        src_q[s].push_back(b);
    endtask

    task automatic add_frame(int s, int n, int maxgap);
        for (int k = 0; k < n; k++) push_beat(s, k == n - 1, $urandom_range(0, maxgap));
    endtask

    // Sources obey AXIS: a presented beat stays put until it is accepted.
    task automatic drive_step();
        for (int i = 0; i < S; i++) begin
            if (s_tvalid[i] && acc[i]) s_tvalid[i] = 1'b0;
            if (!s_tvalid[i] && src_q[i].size() > 0) begin
                if (gapc[i] < src_q[i][0].gap) begin
                    gapc[i]++;
                end else begin
                    beat_t b;
                    b = src_q[i].pop_front();
                    s_tdata[i*DW +: DW] = b.data;
                    s_tkeep[i]  = b.keep;
                    s_tuser[i]  = b.user;
                    s_tlast[i]  = b.last;
                    s_tvalid[i] = 1'b1;
                    exp_q[i].push_back(b);
                    gapc[i] = 0;
                end
            end
        end
    endtask

    task automatic cycle(int mode);
        @(posedge clk);
        #1;
        case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        drive_step();
    endtask

    function automatic bit busy();
        busy = (mst != 0);
        for (int i = 0; i < S; i++)
            if (src_q[i].size() > 0 || exp_q[i].size() > 0 || s_tvalid[i]) busy = 1'b1;
    endfunction

    task automatic run(int mode, int budget, string name);
        int n;
        n = 0;
        do begin
            cycle(mode);
            n++;
        end while (busy() && n < budget);
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    function automatic int order_code();
        order_code = 0;
        foreach (order_q[k]) order_code = order_code * 16 + order_q[k] + 1;
    endfunction

    initial begin
        for (int i = 0; i < S; i++) gapc[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone requester on stream 1, three beats.
        order_q.delete();
        add_frame(1, 3, 0);
        run(0, 200, "single_stream");
        chk("order_single", 64'(order_code()), 64'h2);

        // Two continuously-valid streams alternate frame by frame.
        order_q.delete();
        add_frame(0, 2, 0); add_frame(0, 2, 0);
        add_frame(1, 2, 0); add_frame(1, 2, 0);
        run(0, 200, "alternate");
        chk("order_alternate", 64'(order_code()), 64'h1212);

        // Downstream ready toggling every cycle during a 4-beat frame.
        order_q.delete();
        add_frame(2, 4, 0);
        run(1, 200, "toggle_ready");
        chk("order_toggle", 64'(order_code()), 64'h3);

        // Reset mid-frame abandons stream 2's frame and restores stream 0 priority.
        order_q.delete();
        add_frame(2, 5, 0);
        repeat (4) cycle(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_tready = 1'b0;
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            s_tvalid[i] = 1'b0;
            gapc[i] = 0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_frame(2, 1, 0);
        add_frame(0, 1, 0);
        run(0, 200, "after_reset");
        chk("order_after_reset", 64'(order_code()), 64'h13);

        // Stream 0 stalls mid-frame for longer than TIMEOUT while stream 1 waits.
        order_q.delete();
        tout_seen = 0;
        push_beat(0, 1'b0, 0); push_beat(0, 1'b0, 0); push_beat(0, 1'b0, 12);
        push_beat(0, 1'b0, 0); push_beat(0, 1'b1, 0);
        repeat (2) cycle(0);
        add_frame(1, 1, 0);
        run(0, 500, "stall");
        chk("order_stall", 64'(order_code()), 64'h12);
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
        chk("timeout_pulses", 64'(tout_seen), 64'd1);
`else
        chk("timeout_pulses", 64'(tout_seen), 64'd0);
`endif

        // Random frames, gaps and downstream backpressure.
        for (int f = 0; f < 30; f++) add_frame($urandom_range(0, S - 1), $urandom_range(1, 4), 2);
        run(2, 4000, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
